pipe_rr_sequencer: RTL and testbench
====================================

// Module: pipe_rr_sequencer
// PURPOSE
//  Round-robin sequencer sharing one fixed-latency arithmetic pipeline (e.g. the 10-bit
//  pipelining datapath, f from a,b,c,d) between two requesters. Grants one issue per cycle,
//  drives the pipeline operand bus, tracks in-flight tags and routes each result to its requester.
//  Handles enable/drain sequencing; sits between request sources and the pipeline instance.
// PARAMETERS
//  W    10  operand/result width
//  LAT   3  pipeline latency, cycles from pipe_vld to pipe_f valid (>=1)
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  en        in   1    1 = grants allowed; 0 = stop issuing and drain
//  req0/req1 in   1    requester N holds request + operands until granted
//  op0/op1   in   4*W  operands {a,b,c,d}, a in MSBs
//  gnt0/gnt1 out  1    combinational; req&gnt in cycle T = accepted in T
//  pipe_vld  out  1    registered; operands on pipe_op valid this cycle
//  pipe_op   out  4*W  registered {a,b,c,d} to pipeline
//  pipe_f    in   W    pipeline result
//  rsp_vld0/rsp_vld1 out 1  result for requester N this cycle
//  rsp_f     out  W    = pipe_f (pass-through)
//  busy      out  1    state!=IDLE or any tag in flight
//  state     out  2    00 IDLE, 01 RUN, 10 DRAIN
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt*, pipe_vld, rsp_vld*, busy =0; pipe_op=0; state=IDLE; tags cleared;
//   RR pointer = "last granted 1" so requester 0 wins first tie. In-flight results are discarded.
//  Grant only in RUN. One req -> that req granted every cycle (full throughput). Both req ->
//   grant the one NOT granted last; pointer updates only on an actual grant. Never both gnts.
//  Accept in cycle T -> pipe_vld=1 and pipe_op=that op in T+1; pipe_vld=0 in cycles with no accept.
//  Tag shift register, depth LAT, entry {vld,id}: pipe_vld in cycle T -> rsp_vld<id>=1 in T+LAT,
//   rsp_f=pipe_f same cycle. Responses cannot be stalled; requester must take them.
//  In-flight count = accepted-not-yet-responded; width clog2(LAT+2); never exceeds LAT+1.
//  FSM: IDLE->RUN when en=1. RUN->DRAIN when en=0 and in-flight>0; RUN->IDLE when en=0 and
//   in-flight=0. DRAIN->RUN when en=1 (grants resume next cycle); DRAIN->IDLE in the cycle
//   after the last rsp_vld. en sampled at clock edge; gnt forced 0 in the cycle state!=RUN.
//  Simultaneous accept and rsp in one cycle: count unchanged. busy drops with state entering IDLE.
// CONFIGURATION
//  PIPE_RR_STATS_EN defined: adds outputs cnt0, cnt1 (16 bit each), +1 per accepted request of
//   that requester, wrap at 16'hFFFF->0, reset to 0; clr_stats input (sync, 1 cycle) zeroes both,
//   clear wins over a same-cycle increment.
//  Undefined: cnt0, cnt1, clr_stats ports and counters absent; all other behaviour identical.
// TESTING (W=10, LAT=3)
//  Reset: rst_n=0 -> all outputs 0, state=00, busy=0; no gnt with req0=1,en=0.
//  Single: en=1, req0=1, op0={10,20,12,2} 4 cycles from T -> gnt0 T..T+3, pipe_vld T+1..T+4,
//   rsp_vld0 T+4..T+7 with rsp_f=pipe_f; rsp_vld1 never.
//  Contention: req0=req1=1 for 6 cycles -> gnt order 0,1,0,1,0,1; rsp_vld order identical, 3 later.
//  Drain: 3 in flight, en->0 -> state 10, no gnts with reqs held, 3 rsps, state 00 next cycle, busy=0.
//  Reset mid-flight: rst_n=0 with 2 in flight -> outputs 0 immediately, no rsp_vld after release.
//  Stats (PIPE_RR_STATS_EN): 5 gnt0 + 3 gnt1 -> cnt0=5, cnt1=3; clr_stats -> both 0 next cycle.

Source files
------------

// File: rtl/pipe_rr_sequencer_if.sv
// Request/grant, pipeline operand/result and response bundle for pipe_rr_sequencer.
// The master side belongs to the requesters and the pipeline; the sequencer is the slave.
interface pipe_rr_sequencer_if #(
  parameter int W = 10
);
  logic           req0;
  logic           req1;
  logic [4*W-1:0] op0;
  logic [4*W-1:0] op1;
  logic           gnt0;
  logic           gnt1;
  logic           pipe_vld;
  logic [4*W-1:0] pipe_op;
  logic [W-1:0]   pipe_f;
  logic           rsp_vld0;
  logic           rsp_vld1;
  logic [W-1:0]   rsp_f;

  modport master (
    output req0, req1, op0, op1, pipe_f,
    input  gnt0, gnt1, pipe_vld, pipe_op, rsp_vld0, rsp_vld1, rsp_f
  );

  modport slave (
    input  req0, req1, op0, op1, pipe_f,
    output gnt0, gnt1, pipe_vld, pipe_op, rsp_vld0, rsp_vld1, rsp_f
  );
endinterface

// File: rtl/pipe_rr_sequencer.sv
// Round-robin sequencer sharing one fixed-latency pipeline between two requesters.
// Define PIPE_RR_STATS_EN to add per-requester accept counters (cnt0/cnt1, clr_stats).
module pipe_rr_sequencer #(
  parameter int W   = 10,
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
`ifdef PIPE_RR_STATS_EN
  input  logic                clr_stats,
  output logic [15:0]         cnt0,
  output logic [15:0]         cnt1,
`endif
  pipe_rr_sequencer_if.slave  bus,
  output logic                busy,
  output logic [1:0]          state
);
  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t         cur;
  state_t         nxt;
  logic           last;
  logic           gnt0;
  logic           gnt1;
  logic           accept;
  logic           acc_id;
  logic           pipe_vld_q;
  logic           pipe_id_q;
  logic [4*W-1:0] pipe_op_q;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;
  logic           rsp_fire;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  inflight_nxt;

  // last=1 means requester 1 won most recently, so requester 0 wins a tie after reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (cur == RUN && en) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;
  assign acc_id = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= 1'b0;
      pipe_id_q  <= 1'b0;
      pipe_op_q  <= '0;
      last       <= 1'b1;
    end else begin
      pipe_vld_q <= accept;
      if (accept) begin
        pipe_id_q <= acc_id;
        pipe_op_q <= acc_id ? bus.op1 : bus.op0;
        last      <= acc_id;
      end
    end
  end

  // Tags ride alongside the pipeline so the result LAT cycles later knows its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= pipe_vld_q;
      tag_id[0]  <= pipe_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign rsp_fire = tag_vld[LAT-1];

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !rsp_fire) begin
      inflight_nxt = inflight + CW'(1);
    end else if (!accept && rsp_fire) begin
      inflight_nxt = inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      cur      <= IDLE;
    end else begin
      inflight <= inflight_nxt;
      cur      <= nxt;
    end
  end

  // Leaving RUN/DRAIN looks at the post-edge count so a response landing now ends the drain
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:    if (en) nxt = RUN;
      RUN:     if (!en) nxt = (inflight_nxt != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (en) begin
          nxt = RUN;
        end else if (inflight_nxt == '0) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.pipe_vld = pipe_vld_q;
  assign bus.pipe_op  = pipe_op_q;
  assign bus.rsp_vld0 = rsp_fire & !tag_id[LAT-1];
  assign bus.rsp_vld1 = rsp_fire & tag_id[LAT-1];
  assign bus.rsp_f    = bus.pipe_f;
  assign busy         = (cur != IDLE) || (inflight != '0);
  assign state        = cur;

`ifdef PIPE_RR_STATS_EN
  // Clear takes priority over an accept in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (clr_stats) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0) cnt0 <= cnt0 + 16'd1;
      if (gnt1) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_rr_sequencer.sv
// Directed bench for pipe_rr_sequencer with a sum-of-operands pipeline model of latency LAT.
// Stats checks are compiled in when PIPE_RR_STATS_EN is defined.
module tb_pipe_rr_sequencer;
  localparam int W   = 10;
  localparam int LAT = 3;
  localparam logic [4*W-1:0] OP0 = {10'd10, 10'd20, 10'd12, 10'd2};
  localparam logic [4*W-1:0] OP1 = {10'd1, 10'd2, 10'd3, 10'd4};
  localparam logic [W-1:0] F0 = 10'd44;
  localparam logic [W-1:0] F1 = 10'd10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       busy;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;
`ifdef PIPE_RR_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  pipe_rr_sequencer_if #(.W(W)) bus ();

  pipe_rr_sequencer #(.W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
`ifdef PIPE_RR_STATS_EN
    .clr_stats (clr_stats),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
`endif
    .bus       (bus.slave),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: f = a+b+c+d, LAT cycles after pipe_vld
  logic [W-1:0] mf [LAT];
  logic         mv [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        mf[i] <= '0;
        mv[i] <= 1'b0;
      end
    end else begin
      mv[0] <= bus.pipe_vld;
      mf[0] <= bus.pipe_op[4*W-1:3*W] + bus.pipe_op[3*W-1:2*W]
             + bus.pipe_op[2*W-1:W] + bus.pipe_op[W-1:0];
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        mf[i] <= mf[i-1];
      end
    end
  end

  assign bus.pipe_f = mv[LAT-1] ? mf[LAT-1] : '0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    bus.op0  = OP0;
    bus.op1  = OP1;
    en       = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.pipe_vld, bus.rsp_vld0, bus.rsp_vld1, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 000000",
               {bus.gnt0, bus.gnt1, bus.pipe_vld, bus.rsp_vld0, bus.rsp_vld1, busy});
    end
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_state got %b want 00", state);
    end
    checks++;
    if (bus.pipe_op !== '0 || bus.rsp_f !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data pipe_op %h rsp_f %h want 0", bus.pipe_op, bus.rsp_f);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.gnt1} !== 2'b00 || state !== 2'b00) begin
        errors++;
        $display("[TB] FAIL idle_nogrant k=%0d gnt %b state %b want 00 00",
                 k, {bus.gnt0, bus.gnt1}, state);
      end
      next_cycle();
    end
    bus.req0 = 1'b0;
  endtask

  task automatic test_contention;
    logic eg0, eg1, epv, er0, er1;
    en = 1'b1;
    next_cycle();
    for (int k = 0; k < 11; k++) begin
      bus.req0 = (k < 6);
      bus.req1 = (k < 6);
      @(negedge clk);
      eg0 = (k < 6) && (k % 2 == 0);
      eg1 = (k < 6) && (k % 2 == 1);
      epv = (k >= 1) && (k <= 6);
      er0 = (k == 4) || (k == 6) || (k == 8);
      er1 = (k == 5) || (k == 7) || (k == 9);
      checks++;
      if ({bus.gnt0, bus.gnt1} !== {eg0, eg1}) begin
        errors++;
        $display("[TB] FAIL contention_gnt k=%0d got %b want %b", k, {bus.gnt0, bus.gnt1}, {eg0, eg1});
      end
      checks++;
      if (bus.pipe_vld !== epv || (epv && bus.pipe_op !== ((k % 2 == 1) ? OP0 : OP1))) begin
        errors++;
        $display("[TB] FAIL contention_pipe k=%0d vld %b op %h want vld %b", k, bus.pipe_vld, bus.pipe_op, epv);
      end
      checks++;
      if ({bus.rsp_vld0, bus.rsp_vld1} !== {er0, er1} ||
          ((er0 || er1) && bus.rsp_f !== (er0 ? F0 : F1))) begin
        errors++;
        $display("[TB] FAIL contention_rsp k=%0d got %b f=%0d want %b f=%0d",
                 k, {bus.rsp_vld0, bus.rsp_vld1}, bus.rsp_f, {er0, er1}, er0 ? F0 : F1);
      end
      next_cycle();
    end
  endtask

  task automatic test_single;
    logic eg0, epv, er0;
    for (int k = 0; k < 10; k++) begin
      bus.req0 = (k < 4);
      bus.req1 = 1'b0;
      @(negedge clk);
      eg0 = (k < 4);
      epv = (k >= 1) && (k <= 4);
      er0 = (k >= 4) && (k <= 7);
      checks++;
      if ({bus.gnt0, bus.gnt1} !== {eg0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_gnt k=%0d got %b want %b", k, {bus.gnt0, bus.gnt1}, {eg0, 1'b0});
      end
      checks++;
      if (bus.pipe_vld !== epv || (epv && bus.pipe_op !== OP0)) begin
        errors++;
        $display("[TB] FAIL single_pipe k=%0d vld %b op %h want vld %b op %h", k, bus.pipe_vld, bus.pipe_op, epv, OP0);
      end
      checks++;
      if ({bus.rsp_vld0, bus.rsp_vld1} !== {er0, 1'b0} || (er0 && bus.rsp_f !== F0)) begin
        errors++;
        $display("[TB] FAIL single_rsp k=%0d got %b f=%0d want %b f=%0d",
                 k, {bus.rsp_vld0, bus.rsp_vld1}, bus.rsp_f, {er0, 1'b0}, F0);
      end
      next_cycle();
    end
  endtask

  task automatic test_drain;
    logic       eg0, epv, er0, ebusy;
    logic [1:0] est;
    for (int k = 0; k < 10; k++) begin
      en       = (k < 3);
      bus.req0 = (k < 3) || (k >= 4 && k <= 8);
      bus.req1 = (k >= 4 && k <= 8);
      @(negedge clk);
      eg0   = (k < 3);
      epv   = (k >= 1) && (k <= 3);
      er0   = (k >= 4) && (k <= 6);
      est   = (k <= 3) ? 2'b01 : ((k <= 6) ? 2'b10 : 2'b00);
      ebusy = (k <= 6);
      checks++;
      if ({bus.gnt0, bus.gnt1} !== {eg0, 1'b0} || bus.pipe_vld !== epv) begin
        errors++;
        $display("[TB] FAIL drain_issue k=%0d gnt %b vld %b want %b %b",
                 k, {bus.gnt0, bus.gnt1}, bus.pipe_vld, {eg0, 1'b0}, epv);
      end
      checks++;
      if ({bus.rsp_vld0, bus.rsp_vld1} !== {er0, 1'b0} || (er0 && bus.rsp_f !== F0)) begin
        errors++;
        $display("[TB] FAIL drain_rsp k=%0d got %b f=%0d want %b", k, {bus.rsp_vld0, bus.rsp_vld1}, bus.rsp_f, {er0, 1'b0});
      end
      checks++;
      if (state !== est || busy !== ebusy) begin
        errors++;
        $display("[TB] FAIL drain_state k=%0d state %b busy %b want %b %b", k, state, busy, est, ebusy);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight;
    en = 1'b1;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      bus.req0 = 1'b1;
      next_cycle();
    end
    bus.req0 = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.pipe_vld, bus.rsp_vld0, bus.rsp_vld1, busy} !== 6'b0 ||
        state !== 2'b00 || bus.pipe_op !== '0) begin
      errors++;
      $display("[TB] FAIL midflight_reset ctrl %b state %b op %h want 0",
               {bus.gnt0, bus.gnt1, bus.pipe_vld, bus.rsp_vld0, bus.rsp_vld1, busy}, state, bus.pipe_op);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_vld0, bus.rsp_vld1} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL midflight_rsp k=%0d got %b want 00", k, {bus.rsp_vld0, bus.rsp_vld1});
      end
      if (k == 0) begin
        checks++;
        if (state !== 2'b00) begin
          errors++;
          $display("[TB] FAIL midflight_state got %b want 00", state);
        end
      end
      next_cycle();
    end
  endtask

`ifdef PIPE_RR_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_reset got %0d %0d want 0 0", cnt0, cnt1);
    end
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      bus.req0 = (k < 5);
      bus.req1 = (k >= 5);
      next_cycle();
    end
    bus.req0  = 1'b1;
    bus.req1  = 1'b0;
    clr_stats = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd5 || cnt1 !== 16'd3) begin
      errors++;
      $display("[TB] FAIL stats_count got %0d %0d want 5 3", cnt0, cnt1);
    end
    next_cycle();
    clr_stats = 1'b0;
    bus.req0  = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_clear got %0d %0d want 0 0", cnt0, cnt1);
    end
    next_cycle();
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_after_clear got %0d %0d want 1 0", cnt0, cnt1);
    end
    next_cycle();
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_drain();
    test_reset_midflight();
`ifdef PIPE_RR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
